// File: rtl/mini_src_control_unit.sv
// ============================================================================
// Module   : mini_src_control_unit
// Purpose  : Hardwired Moore control sequencer for the Mini SRC datapath
//            (fetch, jr, jal, br, ldi, addi, nop, halt). Optional Stop
//            input and stall state enabled by macro CTRL_STOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mini_src_control_unit #(
    parameter int         OPW     = 5,
    parameter logic [4:0] ALU_ADD = 5'b00011
) (
    input  logic        Clock,
    input  logic        Reset,
`ifdef CTRL_STOP_EN
    input  logic        Stop,
`endif
    input  logic [31:0] IR,
    input  logic        CON_out,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        Rin,
    output logic        R15in,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  ALUop,
    output logic        Run,
    output logic        Illegal
);

    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b10100);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

`ifdef CTRL_STOP_EN
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        T3     = 4'd4,
        T4     = 4'd5,
        T5     = 4'd6,
        T6     = 4'd7,
        S_HALT = 4'd8,
        S_STOP = 4'd9
    } state_t;
`else
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        T3     = 4'd4,
        T4     = 4'd5,
        T5     = 4'd6,
        T6     = 4'd7,
        S_HALT = 4'd8
    } state_t;
`endif

    state_t         state_q;
    state_t         state_d;
    state_t         w_t0_next;
    logic [OPW-1:0] w_opcode;
    logic           w_is_ldi;
    logic           w_is_addi;
    logic           w_is_br;
    logic           w_is_jr;
    logic           w_is_jal;
    logic           w_is_nop;
    logic           w_is_halt;
    logic           w_is_imm;
    logic           w_legal;
    logic           w_unused_ir;

    assign w_opcode    = IR[31 -: OPW];
    assign w_unused_ir = ^IR[31-OPW:0];

    assign w_is_ldi  = (w_opcode == OP_LDI);
    assign w_is_addi = (w_opcode == OP_ADDI);
    assign w_is_br   = (w_opcode == OP_BR);
    assign w_is_jr   = (w_opcode == OP_JR);
    assign w_is_jal  = (w_opcode == OP_JAL);
    assign w_is_nop  = (w_opcode == OP_NOP);
    assign w_is_halt = (w_opcode == OP_HALT);
    assign w_is_imm  = w_is_ldi | w_is_addi;
    assign w_legal   = w_is_imm | w_is_br | w_is_jr | w_is_jal | w_is_nop | w_is_halt;

    // Every return to fetch goes through this, so a stall can only start at an instruction boundary.
`ifdef CTRL_STOP_EN
    assign w_t0_next = Stop ? S_STOP : T0;
`else
    assign w_t0_next = T0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:  state_d = w_t0_next;
            T0:     state_d = T1;
            T1:     state_d = T2;
            T2:     state_d = T3;
            T3: begin
                if (w_is_jal || w_is_br || w_is_imm) begin
                    state_d = T4;
                end else if (w_is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = w_t0_next;
                end
            end
            T4:     state_d = (w_is_br || w_is_imm) ? T5 : w_t0_next;
            T5:     state_d = w_is_br ? T6 : w_t0_next;
            T6:     state_d = w_t0_next;
            S_HALT: state_d = S_HALT;
`ifdef CTRL_STOP_EN
            S_STOP: state_d = Stop ? S_STOP : T0;
`endif
            default: state_d = S_RST;
        endcase
    end

    // These strobes have no source in this instruction subset.
    assign Write    = 1'b0;
    assign Zhighout = 1'b0;
    assign Grc      = 1'b0;

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        BAout   = 1'b0;
        Rout    = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        Rin     = 1'b0;
        R15in   = 1'b0;
        CONin   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        ALUop   = 5'b00000;
        Run     = 1'b0;
        Illegal = 1'b0;
        case (state_q)
            T0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                Run = 1'b1;
                if (w_is_jr) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else if (w_is_jal) begin
                    PCout = 1'b1;
                    R15in = 1'b1;
                end else if (w_is_br) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end else if (w_is_imm) begin
                    Grb   = 1'b1;
                    BAout = w_is_ldi;
                    Rout  = w_is_addi;
                    Yin   = 1'b1;
                end else if (!w_legal) begin
                    Illegal = 1'b1;
                end
            end
            T4: begin
                Run = 1'b1;
                if (w_is_jal) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else if (w_is_br) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end else if (w_is_imm) begin
                    Cout  = 1'b1;
                    ALUop = ALU_ADD;
                    Zin   = 1'b1;
                end
            end
            T5: begin
                Run = 1'b1;
                if (w_is_br) begin
                    Cout  = 1'b1;
                    ALUop = ALU_ADD;
                    Zin   = 1'b1;
                end else if (w_is_imm) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            T6: begin
                Run     = 1'b1;
                Zlowout = w_is_br;
                // Branch is taken on the condition latched by CONin back in T3.
                PCin    = w_is_br & CON_out;
            end
            default: begin
                Run = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mini_src_control_unit.sv
// ============================================================================
// Module   : tb_mini_src_control_unit
// Purpose  : Self-checking bench for mini_src_control_unit with a per-cycle
//            control-word sequence model and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mini_src_control_unit;

    localparam logic [28:0] M_WRITE   = 29'h1 << 0;
    localparam logic [28:0] M_READ    = 29'h1 << 1;
    localparam logic [28:0] M_INCPC   = 29'h1 << 2;
    localparam logic [28:0] M_GRC     = 29'h1 << 3;
    localparam logic [28:0] M_GRB     = 29'h1 << 4;
    localparam logic [28:0] M_GRA     = 29'h1 << 5;
    localparam logic [28:0] M_CONIN   = 29'h1 << 6;
    localparam logic [28:0] M_R15IN   = 29'h1 << 7;
    localparam logic [28:0] M_RIN     = 29'h1 << 8;
    localparam logic [28:0] M_PCIN    = 29'h1 << 9;
    localparam logic [28:0] M_ZIN     = 29'h1 << 10;
    localparam logic [28:0] M_YIN     = 29'h1 << 11;
    localparam logic [28:0] M_IRIN    = 29'h1 << 12;
    localparam logic [28:0] M_MDRIN   = 29'h1 << 13;
    localparam logic [28:0] M_MARIN   = 29'h1 << 14;
    localparam logic [28:0] M_ROUT    = 29'h1 << 15;
    localparam logic [28:0] M_BAOUT   = 29'h1 << 16;
    localparam logic [28:0] M_COUT    = 29'h1 << 17;
    localparam logic [28:0] M_MDROUT  = 29'h1 << 18;
    localparam logic [28:0] M_ZHIGH   = 29'h1 << 19;
    localparam logic [28:0] M_ZLOW    = 29'h1 << 20;
    localparam logic [28:0] M_PCOUT   = 29'h1 << 21;
    localparam logic [28:0] M_ADD     = 29'h3 << 22;
    localparam logic [28:0] M_ILL     = 29'h1 << 27;
    localparam logic [28:0] M_RUN     = 29'h1 << 28;

    localparam logic [28:0] W_F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [28:0] W_F1 = M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [28:0] W_F2 = M_RUN | M_MDROUT | M_IRIN;

    logic        Clock;
    logic        Reset;
    logic [31:0] IR;
    logic        CON_out;
`ifdef CTRL_STOP_EN
    logic        Stop;
`endif
    logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout;
    logic MARin, MDRin, IRin, Yin, Zin, PCin, Rin, R15in, CONin;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run, Illegal;
    logic [4:0] ALUop;

    logic [28:0] w_ctl;
    logic [28:0] exp_q[$];
    logic [28:0] cap[0:15];
    int          total;
    int          bad;

    mini_src_control_unit dut (
        .Clock(Clock), .Reset(Reset),
`ifdef CTRL_STOP_EN
        .Stop(Stop),
`endif
        .IR(IR), .CON_out(CON_out),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .PCin(PCin), .Rin(Rin), .R15in(R15in), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .ALUop(ALUop), .Run(Run), .Illegal(Illegal)
    );

    assign w_ctl = {Run, Illegal, ALUop, PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout,
                    MARin, MDRin, IRin, Yin, Zin, PCin, Rin, R15in, CONin,
                    Gra, Grb, Grc, IncPC, Read, Write};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Expected control-word sequence for one instruction, fetch included.
    task automatic build(input logic [4:0] op, input logic con);
        exp_q.push_back(W_F0);
        exp_q.push_back(W_F1);
        exp_q.push_back(W_F2);
        case (op)
            5'b10011: exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
            5'b10100: begin
                exp_q.push_back(M_RUN | M_PCOUT | M_R15IN);
                exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
            end
            5'b10010: begin
                exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CONIN);
                exp_q.push_back(M_RUN | M_PCOUT | M_YIN);
                exp_q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
                exp_q.push_back(M_RUN | M_ZLOW | (con ? M_PCIN : 29'h0));
            end
            5'b00001, 5'b01011: begin
                exp_q.push_back(M_RUN | M_GRB | M_YIN | ((op == 5'b00001) ? M_BAOUT : M_ROUT));
                exp_q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
                exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
            end
            5'b11001: exp_q.push_back(M_RUN);
            5'b11010: begin
                exp_q.push_back(M_RUN);
                for (int k = 0; k < 22; k++) exp_q.push_back(29'h0);
            end
            default: exp_q.push_back(M_RUN | M_ILL);
        endcase
    endtask

    always @(negedge Clock) begin
        logic [28:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (w_ctl !== e) begin
                bad++;
                $display("FAIL seq t=%0t: got %h expected %h", $time, w_ctl, e);
            end
        end
    end

    task automatic chk(input string name, input logic [28:0] got, input logic [28:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Starts on the edge that enters T0 and returns once every expected word is consumed.
    task automatic issue(input logic [31:0] ir, input logic con);
        @(posedge Clock);
        #1;
        IR      = ir;
        CON_out = con;
        build(ir[31:27], con);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            #1;
            if (i < 16) cap[i] = w_ctl;
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        Reset   = 1'b1;
        IR      = 32'h0;
        CON_out = 1'b0;
`ifdef CTRL_STOP_EN
        Stop    = 1'b0;
`endif
        repeat (2) begin
            @(negedge Clock);
            #1;
            chk("reset_zero", w_ctl, 29'h0);
        end
        Reset = 1'b0;

        issue(32'hC800_0000, 1'b0);
        chk("fetch_t0", cap[0], W_F0);
        chk("fetch_t1", cap[1], W_F1);
        chk("fetch_t2", cap[2], W_F2);
        chk("nop_t3", cap[3], M_RUN);

        issue(32'hA280_0000, 1'b0);
        chk("jal_t3", cap[3], M_RUN | M_PCOUT | M_R15IN);
        chk("jal_t4", cap[4], M_RUN | M_GRA | M_ROUT | M_PCIN);

        issue(32'h9800_0000, 1'b0);
        chk("jr_t3", cap[3], M_RUN | M_GRA | M_ROUT | M_PCIN);

        issue(32'h9000_0000, 1'b1);
        chk("br_taken_t6", cap[6], M_RUN | M_ZLOW | M_PCIN);
        issue(32'h9000_0000, 1'b0);
        chk("br_not_taken_t6", cap[6], M_RUN | M_ZLOW);

        issue(32'h0880_0004, 1'b0);
        chk("ldi_t3", cap[3], M_RUN | M_GRB | M_BAOUT | M_YIN);
        chk("ldi_aluop", {24'h0, cap[4][26:22]}, 29'h3);
        chk("ldi_t5", cap[5], M_RUN | M_ZLOW | M_GRA | M_RIN);

        issue(32'h5800_0000, 1'b0);
        chk("addi_t3", cap[3], M_RUN | M_GRB | M_ROUT | M_YIN);

        issue(32'hF800_0000, 1'b0);
        chk("illegal_t3", cap[3], M_RUN | M_ILL);

        issue(32'hD000_0000, 1'b0);
        chk("halt_run", {28'h0, cap[10][28]}, 29'h0);

        // Release from halt through reset, then abort a br in T5.
        @(negedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        chk("halt_reset_zero", w_ctl, 29'h0);
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        IR = 32'h9000_0000;
        chk("restart_t0", w_ctl, W_F0);
        repeat (5) @(posedge Clock);
        #1;
        chk("br_t5", w_ctl, M_RUN | M_COUT | M_ADD | M_ZIN);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_zero", w_ctl, 29'h0);
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("post_reset_t0", w_ctl, W_F0);

`ifdef CTRL_STOP_EN
        IR   = 32'hC800_0000;
        Stop = 1'b1;
        @(posedge Clock);
        #1;
        chk("stop_ignored_t1", w_ctl, W_F1);
        repeat (2) @(posedge Clock);
        repeat (3) begin
            @(posedge Clock);
            #1;
            chk("stop_hold", w_ctl, 29'h0);
        end
        Stop = 1'b0;
        @(posedge Clock);
        #1;
        chk("stop_resume_t0", w_ctl, W_F0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
